// File: rtl/keycode_action_mapper.sv
// Scans USB boot-report keycode slots against a programmable key-to-action table
// and publishes held levels plus frame-synchronous press/release/repeat flags.
//
// state  | meaning
// IDLE   | ready for a report or a table write
// SCAN   | one keycode slot compared against the table per cycle
// COMMIT | pending mask copied to action_held unless the report rolled over
module keycode_action_mapper #(
    parameter int NUM_SLOTS    = 6,
    parameter int NUM_ACTIONS  = 6,
    parameter int KEY_W        = 8,
    parameter logic [NUM_ACTIONS*KEY_W-1:0] DEFAULT_MAP =
        {8'h4F, 8'h50, 8'h52, 8'h07, 8'h04, 8'h1A},
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             report_valid,
    input  logic [NUM_SLOTS*KEY_W-1:0]       report_keycodes,
    output logic                             report_ready,
    input  logic                             map_we,
    input  logic [$clog2(NUM_ACTIONS)-1:0]   map_addr,
    input  logic [KEY_W-1:0]                 map_key,
    input  logic                             frame_tick,
    output logic [NUM_ACTIONS-1:0]           action_held,
    output logic [NUM_ACTIONS-1:0]           action_press,
    output logic [NUM_ACTIONS-1:0]           action_release,
    output logic [NUM_ACTIONS-1:0]           action_repeat,
    output logic                             busy
);

    localparam int ADDR_W = $clog2(NUM_ACTIONS);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W  = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]  FIRE_AT   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]  RELOAD    = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [KEY_W-1:0]  KEY_NONE  = '0;
    localparam logic [KEY_W-1:0]  KEY_ROLL  = KEY_W'(1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                     state_q, state_d;
    logic                       armed_q;
    logic                       accept;
    logic [NUM_SLOTS*KEY_W-1:0] buf_q;
    logic [SLOT_W-1:0]          slot_q;
    logic [KEY_W-1:0]           slot_key;
    logic [NUM_ACTIONS-1:0]     match;
    logic [NUM_ACTIONS-1:0]     pending_q;
    logic                       rollover_q;
    logic [NUM_ACTIONS-1:0]     held_q, prev_q, press_q, release_q, repeat_q;
    logic [KEY_W-1:0]           table_q [NUM_ACTIONS];
    logic [CNT_W-1:0]           cnt_q   [NUM_ACTIONS];
    logic [2:0]                 ft_sync_q;
    logic                       fe;

    // The buffer shifts right each scan cycle, so the current slot is always the low field.
    assign slot_key = buf_q[KEY_W-1:0];

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            match[i] = (slot_key != KEY_NONE) && (slot_key == table_q[i]);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        report_ready = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                report_ready = armed_q & ~map_we;
                accept       = report_valid & armed_q & ~map_we;
                if (accept) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (slot_q == LAST_SLOT) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // armed_q keeps report_ready low while and just after Reset is asserted.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            armed_q    <= 1'b0;
            buf_q      <= '0;
            slot_q     <= '0;
            pending_q  <= '0;
            rollover_q <= 1'b0;
            held_q     <= '0;
            for (int i = 0; i < NUM_ACTIONS; i++) begin
                table_q[i] <= DEFAULT_MAP[i*KEY_W +: KEY_W];
            end
        end else begin
            armed_q <= 1'b1;
            if (accept) begin
                buf_q      <= report_keycodes;
                slot_q     <= '0;
                pending_q  <= '0;
                rollover_q <= 1'b0;
            end
            if (state_q == SCAN) begin
                buf_q     <= buf_q >> KEY_W;
                slot_q    <= slot_q + SLOT_W'(1);
                pending_q <= pending_q | match;
                if (slot_key == KEY_ROLL) begin
                    rollover_q <= 1'b1;
                end
            end
            if (state_q == COMMIT && !rollover_q) begin
                held_q <= pending_q;
            end
            if (state_q == IDLE && map_we) begin
                for (int i = 0; i < NUM_ACTIONS; i++) begin
                    if (map_addr == ADDR_W'(i)) begin
                        table_q[i] <= map_key;
                    end
                end
            end
        end
    end

    assign fe = ft_sync_q[1] & ~ft_sync_q[2];

    // Frame-edge outputs only move on fe, so they hold steady for a whole frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ft_sync_q <= '0;
            prev_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < NUM_ACTIONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ft_sync_q <= {ft_sync_q[1:0], frame_tick};
            if (fe) begin
                press_q   <= held_q & ~prev_q;
                release_q <= ~held_q & prev_q;
                prev_q    <= held_q;
                for (int i = 0; i < NUM_ACTIONS; i++) begin
                    if (!held_q[i]) begin
                        cnt_q[i]    <= '0;
                        repeat_q[i] <= 1'b0;
                    end else if (cnt_q[i] == FIRE_AT) begin
                        cnt_q[i]    <= RELOAD;
                        repeat_q[i] <= 1'b1;
                    end else begin
                        repeat_q[i] <= 1'b0;
                        if (cnt_q[i] != CNT_MAX) begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign action_held    = held_q;
    assign action_press   = press_q;
    assign action_release = release_q;
    assign action_repeat  = repeat_q;

endmodule
